image_pixel_pipe: RTL

Parametrised, pipelined successor to the combinational image-mode decoder in the VGA path. It pulls packed pixel words from the frame-buffer fetch logic over a valid/ready handshake and unpacks 1, 2 or 4 pixels per 16-bit lane (RGB565, RGB332, GRAY4). It applies horizontal pixel repetition (1x/2x/4x) and drives registered RGB565 onto the shared tri-state colour bus alongside the text-mode renderer.

---
 rtl/vga_pix_pkg.sv | 55 +++++
 rtl/pix_expand.sv | 21 ++
 rtl/image_pixel_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vga_pix_pkg.sv
// rtl/vga_pix_pkg.sv - pixel format encodings, channel widths and RGB565 expansion helpers
package vga_pix_pkg;

    typedef enum logic [1:0] {
        FMT_RGB565 = 2'd0,
        FMT_RGB332 = 2'd1,
        FMT_GRAY4  = 2'd2,
        FMT_RSVD   = 2'd3
    } pix_fmt_e;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    // Number of pixels packed into one fetch word for a given format.
    function automatic int pix_per_word(input pix_fmt_e fmt, input int word_w);
        case (fmt)
            FMT_RGB332: return word_w / 8;
            FMT_GRAY4:  return word_w / 4;
            default:    return word_w / 16;
        endcase
    endfunction

    function automatic rgb565_t expand_565(input logic [15:0] p);
        rgb565_t c;
        c.r = p[15:11];
        c.g = p[10:5];
        c.b = p[4:0];
        return c;
    endfunction

    // r3 g3 b2 with blue in the LSBs; widen each channel by bit replication.
    function automatic rgb565_t expand_332(input logic [7:0] p);
        rgb565_t c;
        c.r = {p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2]};
        c.b = {p[1:0], p[1:0], p[1]};
        return c;
    endfunction

    function automatic rgb565_t expand_gray4(input logic [3:0] y);
        rgb565_t c;
        c.r = {y, y[3]};
        c.g = {y, y[3:2]};
        c.b = {y, y[3]};
        return c;
    endfunction

endpackage

// File: rtl/pix_expand.sv
// rtl/pix_expand.sv - combinational raw pixel to RGB565 expansion
module pix_expand
    import vga_pix_pkg::*;
(
    input  pix_fmt_e      fmt,
    input  logic [15:0]   raw,
    output rgb565_t       rgb
);

    // Reserved format is rendered black.
    always_comb begin
        rgb = '0;
        case (fmt)
            FMT_RGB565: rgb = expand_565(raw);
            FMT_RGB332: rgb = expand_332(raw[7:0]);
            FMT_GRAY4:  rgb = expand_gray4(raw[3:0]);
            default:    rgb = '0;
        endcase
    end

endmodule

// File: rtl/image_pixel_pipe.sv
// rtl/image_pixel_pipe.sv - image-mode pixel unpack, repeat and RGB565 drive pipeline
module image_pixel_pipe
    import vga_pix_pkg::*;
#(
    parameter int WORD_W         = 16,
    parameter int MAX_SCALE_LOG2 = 2,
    parameter int LAT            = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mode,
    input  logic [1:0]        i_fmt,
    input  logic [1:0]        i_hscale,
    input  logic              i_line_start,
    input  logic              i_active,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_word_valid,
    output logic              o_word_ready,
    output logic              o_active,
    output tri   [R_W-1:0]    o_red,
    output tri   [G_W-1:0]    o_green,
    output tri   [B_W-1:0]    o_blue,
    output logic              o_underrun
);

    localparam int IDX_W = $clog2(WORD_W / 4);
    localparam int REP_W = (MAX_SCALE_LOG2 > 0) ? MAX_SCALE_LOG2 : 1;

    logic              held;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  sub_idx;
    logic [REP_W-1:0]  rep_cnt;
    pix_fmt_e          fmt_sh;
    logic [1:0]        hs_sh;

    logic [1:0]        hs_eff;
    logic [REP_W-1:0]  rep_max;
    logic              last_rep;
    logic              last_sub;
    logic              consume;
    logic              underrun;
    logic              word_done;
    logic              accept;

    logic [WORD_W-1:0] shifted;
    logic [15:0]       pix_sel;

    logic [15:0]       s1_raw;
    pix_fmt_e          s1_fmt;
    logic [LAT-1:0]    act_sr;
    rgb565_t           s2_rgb;
    rgb565_t           exp_rgb;
    logic              drive;

    assign hs_eff    = (int'(hs_sh) > MAX_SCALE_LOG2) ? 2'(MAX_SCALE_LOG2) : hs_sh;
    assign rep_max   = REP_W'((1 << hs_eff) - 1);
    assign last_rep  = (rep_cnt == rep_max);
    assign last_sub  = (sub_idx == IDX_W'(pix_per_word(fmt_sh, WORD_W) - 1));
    assign consume   = i_active && !i_mode && held;
    assign underrun  = i_active && !i_mode && !held;
    assign word_done = consume && last_rep && last_sub;

    // A line start flushes the hold register, so a word offered with it is always taken.
    assign o_word_ready = !held || word_done || i_line_start;
    assign accept       = i_word_valid && o_word_ready;

    // Pick the current sub-pixel out of the held word, LSB-first.
    always_comb begin
        shifted = '0;
        pix_sel = '0;
        case (fmt_sh)
            FMT_RGB332: begin
                shifted = word_q >> {sub_idx, 3'b000};
                pix_sel = {8'd0, shifted[7:0]};
            end
            FMT_GRAY4: begin
                shifted = word_q >> {sub_idx, 2'b00};
                pix_sel = {12'd0, shifted[3:0]};
            end
            default: begin
                shifted = word_q >> {sub_idx, 4'b0000};
                pix_sel = shifted[15:0];
            end
        endcase
    end

    // Hold register, sub-pixel/repeat counters and per-line config shadows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            held    <= 1'b0;
            word_q  <= '0;
            sub_idx <= '0;
            rep_cnt <= '0;
            fmt_sh  <= FMT_RGB565;
            hs_sh   <= '0;
        end else if (i_line_start) begin
            held    <= i_word_valid;
            if (i_word_valid) begin
                word_q <= i_word;
            end
            sub_idx <= '0;
            rep_cnt <= '0;
            fmt_sh  <= pix_fmt_e'(i_fmt);
            hs_sh   <= i_hscale;
        end else begin
            if (consume) begin
                if (last_rep) begin
                    rep_cnt <= '0;
                    sub_idx <= last_sub ? '0 : sub_idx + IDX_W'(1);
                end else begin
                    rep_cnt <= rep_cnt + REP_W'(1);
                end
            end
            if (accept) begin
                held   <= 1'b1;
                word_q <= i_word;
            end else if (word_done) begin
                held <= 1'b0;
            end
        end
    end

    // Sticky underrun flag, re-armed at each line start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_underrun <= 1'b0;
        end else if (i_line_start) begin
            o_underrun <= underrun;
        end else if (underrun) begin
            o_underrun <= 1'b1;
        end
    end

    // Stage 1: selected raw pixel (zero when nothing is consumed, which renders black).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_raw <= '0;
            s1_fmt <= FMT_RGB565;
        end else begin
            s1_raw <= consume ? pix_sel : 16'd0;
            s1_fmt <= fmt_sh;
        end
    end

    // Active flag delay line matching the colour pipeline depth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            act_sr <= '0;
        end else begin
            act_sr <= {act_sr[LAT-2:0], i_active};
        end
    end

    pix_expand u_expand (
        .fmt (s1_fmt),
        .raw (s1_raw),
        .rgb (exp_rgb)
    );

    // Stage 2: expanded RGB565 colour.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_rgb <= '0;
        end else begin
            s2_rgb <= exp_rgb;
        end
    end

    assign o_active = act_sr[LAT-1];

    // Release the shared bus whenever text mode owns it or the pipeline is idle.
    assign drive   = act_sr[LAT-1] && !i_mode;
    assign o_red   = drive ? s2_rgb.r : 'z;
    assign o_green = drive ? s2_rgb.g : 'z;
    assign o_blue  = drive ? s2_rgb.b : 'z;

endmodule
